ibuf_loader: RTL



---
 rtl/ibuf_loader_pkg.sv | 30 +++
 rtl/ibuf_line_packer.sv | 46 ++++
 rtl/ibuf_loader.sv | 115 +++++++++++
 3 files changed

// File: rtl/ibuf_loader_pkg.sv
// Shared definitions for the instruction-buffer loader: geometry, FSM
// encoding and the byte-lane insert helper.
package ibuf_loader_pkg;

   localparam int ADDR_W     = 13;
   localparam int LINE_BYTES = 8;
   localparam int DATA_W     = 8 * LINE_BYTES;
   localparam int CNT_W      = 14;
   localparam int IDX_W      = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   // Little-endian packing: lane idx occupies bits idx*8+7 : idx*8.
   function automatic logic [DATA_W-1:0] lane_insert(
      input logic [DATA_W-1:0] line,
      input logic [IDX_W-1:0]  idx,
      input logic [7:0]        data
   );
      logic [DATA_W-1:0] res;
      res = line;
      res[{idx, 3'b000} +: 8] = data;
      return res;
   endfunction

endpackage

// File: rtl/ibuf_line_packer.sv
// Assembles accepted bytes into one SRAM line and keeps the session's
// running XOR checksum.
module ibuf_line_packer
   import ibuf_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              accept,
   input  logic [7:0]        data,
   output logic              line_full,
   output logic [DATA_W-1:0] line,
   output logic [7:0]        csum
);

   logic [IDX_W-1:0]  idx_r;
   logic [DATA_W-1:0] line_r;
   logic [7:0]        csum_r;

   // Byte index, lane-insert shift register and checksum accumulation
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_r  <= {IDX_W{1'b0}};
         line_r <= {DATA_W{1'b0}};
         csum_r <= 8'h00;
      end else if (clear) begin
         idx_r  <= {IDX_W{1'b0}};
         line_r <= {DATA_W{1'b0}};
         csum_r <= 8'h00;
      end else if (accept) begin
         // the index wraps to 0 naturally after lane 7
         idx_r  <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
         line_r <= lane_insert(line_r, idx_r, data);
         csum_r <= csum_r ^ data;
      end else begin
         idx_r  <= idx_r;
         line_r <= line_r;
         csum_r <= csum_r;
      end
   end

   assign line_full = (idx_r == {IDX_W{1'b1}});
   assign line      = line_r;
   assign csum      = csum_r;

endmodule

// File: rtl/ibuf_loader.sv
// Write-side initiator for the IFU instruction buffer: packs a byte stream
// into 64-bit lines and writes one line per strobe while holding busy.
module ibuf_loader
   import ibuf_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  line_cnt,
   input  logic              abort,
   input  logic              byte_vld,
   input  logic [7:0]        byte_data,
   output logic              byte_rdy,
   output logic              wr_H_rd_L,
   output logic [ADDR_W-1:0] wraddr,
   output logic [DATA_W-1:0] wrdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        csum
);

   state_t            state_r;
   logic [ADDR_W-1:0] cur_addr_r;
   logic [CNT_W-1:0]  remaining_r;
   logic              hs_s;
   logic              clear_s;
   logic              accept_s;
   logic              line_full_s;
   logic [DATA_W-1:0] line_s;

   assign byte_rdy = (state_r == ST_FILL);
   assign hs_s     = byte_vld & byte_rdy;
   assign clear_s  = (state_r == ST_IDLE) & load_start & (line_cnt != {CNT_W{1'b0}});
   // a byte handshaking alongside abort is consumed but never accumulated
   assign accept_s = hs_s & ~abort;

   ibuf_line_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_s),
      .accept    (accept_s),
      .data      (byte_data),
      .line_full (line_full_s),
      .line      (line_s),
      .csum      (csum)
   );

   // Session FSM with registered strobes, address and line counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         cur_addr_r  <= {ADDR_W{1'b0}};
         remaining_r <= {CNT_W{1'b0}};
         wr_H_rd_L   <= 1'b0;
         wraddr      <= {ADDR_W{1'b0}};
         wrdata      <= {DATA_W{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         wr_H_rd_L <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               busy <= 1'b0;
               if (load_start) begin
                  if (line_cnt != {CNT_W{1'b0}}) begin
                     cur_addr_r  <= base_addr;
                     remaining_r <= line_cnt;
                     busy        <= 1'b1;
                     state_r     <= ST_FILL;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_FILL: begin
               if (abort) begin
                  err     <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end else if (hs_s && line_full_s) begin
                  wrdata    <= lane_insert(line_s, {IDX_W{1'b1}}, byte_data);
                  wraddr    <= cur_addr_r;
                  wr_H_rd_L <= 1'b1;
                  state_r   <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               // address wraps modulo 2^ADDR_W
               cur_addr_r  <= cur_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               remaining_r <= remaining_r - {{(CNT_W-1){1'b0}}, 1'b1};
               if (remaining_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  done    <= 1'b1;
                  state_r <= ST_FINISH;
               end else begin
                  state_r <= ST_FILL;
               end
            end
            ST_FINISH: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
